wb_stage: RTL and testbench

//  Write-back stage directly downstream of the MEM stage; consumes its registered WB_CTRL/WB_DATA bundle.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_load_ext.sv | 17 +
 rtl/wb_stage.sv | 69 ++++++
 tb/tb_wb_stage.sv | 129 ++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: WB_CTRL bit positions, WB_DATA field slices and WB_BACK width shared by the write-back stage.
package wb_pkg;
  localparam int CTL_REGW = 4;
  localparam int CTL_M2R = 3;
  localparam int CTL_BYTE = 2;
  localparam int CTL_HALF = 1;
  localparam int CTL_UNS = 0;
  localparam int RW_HI = 68;
  localparam int RW_LO = 64;
  localparam int EX_HI = 63;
  localparam int EX_LO = 32;
  localparam int MEM_HI = 31;
  localparam int MEM_LO = 0;
  localparam int WB_BACK_W = 38;
endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: aligns a byte/half/word out of the loaded word and zero- or sign-extends it.
module wb_load_ext (
  input  logic [31:0] mem,
  input  logic [1:0]  addr,
  input  logic        is_byte,
  input  logic        is_half,
  input  logic        uns,
  output logic [31:0] val
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = mem[{addr, 3'b000} +: 8];
    h = addr[1] ? mem[31:16] : mem[15:0];
    val = is_byte ? {{24{~uns & b[7]}}, b} : is_half ? {{16{~uns & h[15]}}, h} : mem;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage with regfile, write-through read ports, forwarding bundle and retire counter.
// Define WB_TRACE_EN to add a registered commit trace (o_tr_valid/o_tr_rw/o_tr_wd).
module wb_stage
  import wb_pkg::*;
#(
  parameter int NREG = 32,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 WB_STALL,
  input  logic [4:0]           WB_CTRL,
  input  logic [68:0]          WB_DATA,
  input  logic [4:0]           ra1,
  input  logic [4:0]           ra2,
  output logic [31:0]          rd1,
  output logic [31:0]          rd2,
  output logic [WB_BACK_W-1:0] o_WB_BACK,
  output logic [CNT_W-1:0]     o_retired
`ifdef WB_TRACE_EN
  ,
  output logic                 o_tr_valid,
  output logic [4:0]           o_tr_rw,
  output logic [31:0]          o_tr_wd
`endif
);
  logic [31:0] regs [NREG];
  logic [4:0]  rw;
  logic [31:0] ex, ld, wd;
  logic        we;
  assign rw = WB_DATA[RW_HI:RW_LO];
  assign ex = WB_DATA[EX_HI:EX_LO];
  wb_load_ext u_ext (
    .mem(WB_DATA[MEM_HI:MEM_LO]),
    .addr(ex[1:0]),
    .is_byte(WB_CTRL[CTL_BYTE]),
    .is_half(WB_CTRL[CTL_HALF]),
    .uns(WB_CTRL[CTL_UNS]),
    .val(ld)
  );
  // rst gates the enable so reset also kills the same-cycle bypass
  always_comb begin
    wd = WB_CTRL[CTL_M2R] ? ld : ex;
    we = rst & WB_CTRL[CTL_REGW] & ~WB_STALL & (rw != 5'd0);
    rd1 = (ra1 == 5'd0) ? 32'd0 : (we && ra1 == rw) ? wd : regs[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : (we && ra2 == rw) ? wd : regs[ra2];
    o_WB_BACK = {WB_CTRL[CTL_REGW] & ~WB_STALL, wd, rw};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      o_retired <= '0;
    end else begin
      if (we) regs[rw] <= wd;
      if (WB_CTRL != 5'd0 && !WB_STALL) o_retired <= o_retired + CNT_W'(1);
    end
`ifdef WB_TRACE_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      o_tr_valid <= 1'b0;
      o_tr_rw <= '0;
      o_tr_wd <= '0;
    end else begin
      o_tr_valid <= we;
      o_tr_rw <= rw;
      o_tr_wd <= wd;
    end
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven check of wb_stage plus reset, first-write and counter-wrap sequences.
module tb_wb_stage;
  logic        clk = 0, rst = 0, stall = 0;
  logic [4:0]  ctrl = 0, ra1 = 0, ra2 = 0;
  logic [68:0] data = 0;
  logic [31:0] rd1, rd2, s_rd1, s_rd2;
  logic [37:0] back, s_back;
  logic [31:0] ret;
  logic [3:0]  s_ret;
  int pass = 0, total = 0;
`ifdef WB_TRACE_EN
  logic tr_v, s_tr_v;
  logic [4:0] tr_rw, s_tr_rw;
  logic [31:0] tr_wd, s_tr_wd;
`endif
  always #5 clk = ~clk;
  wb_stage dut (
    .clk(clk), .rst(rst), .WB_STALL(stall), .WB_CTRL(ctrl), .WB_DATA(data),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .o_WB_BACK(back), .o_retired(ret)
`ifdef WB_TRACE_EN
    , .o_tr_valid(tr_v), .o_tr_rw(tr_rw), .o_tr_wd(tr_wd)
`endif
  );
  wb_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .WB_STALL(stall), .WB_CTRL(ctrl), .WB_DATA(data),
    .ra1(ra1), .ra2(ra2), .rd1(s_rd1), .rd2(s_rd2), .o_WB_BACK(s_back), .o_retired(s_ret)
`ifdef WB_TRACE_EN
    , .o_tr_valid(s_tr_v), .o_tr_rw(s_tr_rw), .o_tr_wd(s_tr_wd)
`endif
  );
  typedef struct {
    logic [4:0]  ctrl;
    logic        stall;
    logic [4:0]  rw;
    logic [31:0] ex, mem;
    logic [4:0]  ra1, ra2;
    logic [31:0] e_rd1, e_rd2, e_wd;
    logic        e_v;
  } vec_t;
  vec_t v [13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  initial begin
    int exp_cnt;
    logic pw;
    logic [4:0] prw;
    logic [31:0] pwd;
    v[0]  = '{5'b10000, 0, 5'd3,  32'hDEADBEEF, 32'h0,        5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1};
    v[1]  = '{5'b00000, 0, 5'd3,  32'h11111111, 32'h0,        5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        32'h11111111, 0};
    v[2]  = '{5'b11100, 0, 5'd4,  32'h0,        32'h8070F0A5, 5'd4,  5'd3,  32'hFFFFFFA5, 32'hDEADBEEF, 32'hFFFFFFA5, 1};
    v[3]  = '{5'b11101, 0, 5'd5,  32'h2,        32'h8070F0A5, 5'd4,  5'd5,  32'hFFFFFFA5, 32'h00000070, 32'h00000070, 1};
    v[4]  = '{5'b11010, 0, 5'd6,  32'h2,        32'h8070F0A5, 5'd6,  5'd5,  32'hFFFF8070, 32'h00000070, 32'hFFFF8070, 1};
    v[5]  = '{5'b11011, 0, 5'd7,  32'h3,        32'h8070F0A5, 5'd7,  5'd7,  32'h00008070, 32'h00008070, 32'h00008070, 1};
    v[6]  = '{5'b11000, 0, 5'd8,  32'h100,      32'h8070F0A5, 5'd8,  5'd6,  32'h8070F0A5, 32'hFFFF8070, 32'h8070F0A5, 1};
    v[7]  = '{5'b11110, 0, 5'd9,  32'h1,        32'h8070F0A5, 5'd9,  5'd0,  32'hFFFFFFF0, 32'h0,        32'hFFFFFFF0, 1};
    v[8]  = '{5'b10000, 0, 5'd0,  32'h1234,     32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h00001234, 1};
    v[9]  = '{5'b10000, 1, 5'd3,  32'hCAFEF00D, 32'h0,        5'd3,  5'd9,  32'hDEADBEEF, 32'hFFFFFFF0, 32'hCAFEF00D, 0};
    v[10] = '{5'b00000, 0, 5'd3,  32'h0,        32'h0,        5'd3,  5'd8,  32'hDEADBEEF, 32'h8070F0A5, 32'h0,        0};
    v[11] = '{5'b11101, 0, 5'd31, 32'h3,        32'h8070F0A5, 5'd31, 5'd31, 32'h00000080, 32'h00000080, 32'h00000080, 1};
    v[12] = '{5'b00000, 0, 5'd31, 32'h0,        32'h0,        5'd31, 5'd7,  32'h00000080, 32'h00008070, 32'h0,        0};
    ra1 = 5'd3;
    #12;
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_retired", ret, 32'h0);
`ifdef WB_TRACE_EN
    chk("reset_tr_valid", {31'd0, tr_v}, 32'h0);
`endif
    rst = 1;
    exp_cnt = 0;
    pw = 0; prw = 0; pwd = 0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      ctrl = v[i].ctrl; stall = v[i].stall; ra1 = v[i].ra1; ra2 = v[i].ra2;
      data = {v[i].rw, v[i].ex, v[i].mem};
      #1;
      chk($sformatf("v%0d_rd1", i), rd1, v[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), rd2, v[i].e_rd2);
      chk($sformatf("v%0d_back_v", i), {31'd0, back[37]}, {31'd0, v[i].e_v});
      chk($sformatf("v%0d_back_wd", i), back[36:5], v[i].e_wd);
      chk($sformatf("v%0d_back_rw", i), {27'd0, back[4:0]}, {27'd0, v[i].rw});
      chk($sformatf("v%0d_retired", i), ret, exp_cnt);
`ifdef WB_TRACE_EN
      chk($sformatf("v%0d_tr_valid", i), {31'd0, tr_v}, {31'd0, pw});
      if (pw) begin
        chk($sformatf("v%0d_tr_rw", i), {27'd0, tr_rw}, {27'd0, prw});
        chk($sformatf("v%0d_tr_wd", i), tr_wd, pwd);
      end
`endif
      pw = v[i].ctrl[4] && !v[i].stall && v[i].rw != 0;
      prw = v[i].rw; pwd = v[i].e_wd;
      if (v[i].ctrl != 0 && !v[i].stall) exp_cnt++;
    end
    @(posedge clk); #1;
    ctrl = 5'b00000; stall = 0; #1;
    chk("table_retired_total", ret, exp_cnt);
    // Reset arrives while a write to r5 is in flight.
    ctrl = 5'b10000; data = {5'd5, 32'h00000055, 32'h0}; ra1 = 5'd5; ra2 = 5'd3;
    #1;
    chk("pre_reset_bypass", rd1, 32'h00000055);
    #1; rst = 0; #1;
    chk("mid_reset_rd1", rd1, 32'h0);
    chk("mid_reset_rd2", rd2, 32'h0);
    chk("mid_reset_retired", ret, 32'h0);
    @(posedge clk); #1;
    chk("reset_hold_rd2", rd2, 32'h0);
    rst = 1;
    @(posedge clk); #1;
    ctrl = 5'b00000; #1;
    chk("first_write_r5", rd1, 32'h00000055);
    chk("first_write_retired", ret, 32'd1);
    chk("small_retired_1", {28'd0, s_ret}, 32'd1);
    // Narrow counter instance: 15 -> wrap to 0.
    ctrl = 5'b10000; data = {5'd1, 32'h00000011, 32'h0}; ra1 = 5'd1;
    repeat (14) @(posedge clk);
    #1; ctrl = 5'b00000; #1;
    chk("small_retired_15", {28'd0, s_ret}, 32'd15);
    ctrl = 5'b10000; data = {5'd1, 32'hABCD0000, 32'h0};
    @(posedge clk); #1;
    ctrl = 5'b00000; #1;
    chk("small_retired_wrap", {28'd0, s_ret}, 32'd0);
    chk("retired_16", ret, 32'd16);
    chk("last_write_r1", rd1, 32'hABCD0000);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
